// File: rtl/rbm_gibbs_sequencer.sv
// Gibbs iteration controller: drives hidden sampler and classifier handshakes,
// skips burn-in iterations, then accumulates class outputs into saturating votes.
module rbm_gibbs_sequencer #(
  parameter int out_dim          = 2,
  parameter int output_bitlength = 12,
  parameter int burn_in          = 10,
  parameter int num_samples      = 10
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 h_start,
  input  logic                                 h_done,
  output logic                                 c_start,
  input  logic                                 c_done,
  input  logic [out_dim*output_bitlength-1:0]  ClassI,
  output logic [out_dim*output_bitlength-1:0]  Output,
  output logic [out_dim*output_bitlength-1:0]  ResultO,
  output logic [15:0]                          iter,
  output logic                                 busy,
  output logic                                 finish
);

  localparam logic [15:0] BURN = 16'(burn_in);
  localparam logic [15:0] LAST = 16'(burn_in + num_samples - 1);

  typedef enum logic [2:0] {
    IDLE, H_RUN, H_WAIT, C_RUN, C_WAIT, ACCUM, DONE
  } state_t;

  state_t state;
  logic   in_sample;
  logic [out_dim*output_bitlength-1:0] sat_sum;

  // Per-element unsigned add with one guard bit; clamp to all-ones on carry out.
  for (genvar k = 0; k < out_dim; k++) begin : g_sat
    logic [output_bitlength:0] sum;
    assign sum = {1'b0, ResultO[k*output_bitlength +: output_bitlength]}
               + {1'b0, Output[k*output_bitlength +: output_bitlength]};
    assign sat_sum[k*output_bitlength +: output_bitlength] =
      sum[output_bitlength] ? {output_bitlength{1'b1}} : sum[output_bitlength-1:0];
  end

  // in_sample tracks iter >= burn_in without a constant compare when burn_in is 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      h_start   <= 1'b0;
      c_start   <= 1'b0;
      busy      <= 1'b0;
      finish    <= 1'b0;
      Output    <= '0;
      ResultO   <= '0;
      iter      <= '0;
      in_sample <= 1'b0;
    end else begin
      h_start <= 1'b0;
      c_start <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            Output    <= '0;
            ResultO   <= '0;
            iter      <= '0;
            in_sample <= (BURN == 16'd0);
            h_start   <= 1'b1;
            busy      <= 1'b1;
            finish    <= 1'b0;
            state     <= H_RUN;
          end
        end
        H_RUN: state <= H_WAIT;
        H_WAIT: begin
          if (h_done) begin
            c_start <= 1'b1;
            state   <= C_RUN;
          end
        end
        C_RUN: state <= C_WAIT;
        C_WAIT: begin
          if (c_done) begin
            Output <= ClassI;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_sample) ResultO <= sat_sum;
          if (iter == LAST) begin
            busy   <= 1'b0;
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            iter    <= iter + 16'd1;
            h_start <= 1'b1;
            state   <= H_RUN;
            if (iter + 16'd1 == BURN) in_sample <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rbm_gibbs_sequencer.sv
// Scoreboard bench for rbm_gibbs_sequencer: three instances cover the nominal,
// burn-in exclusion and 2-bit saturation configurations.
module tb_rbm_gibbs_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  int tests = 0;
  int fails = 0;
  int start_edge = 0;

  logic        start_s[3], h_done_s[3], c_done_s[3];
  logic [23:0] cls_s[3];
  logic        h_st[3], c_st[3], busy_s[3], fin_s[3];
  logic [23:0] out_s[3], res_s[3];
  logic [15:0] iter_s[3];

  logic        h_start_a, c_start_a, busy_a, finish_a;
  logic [23:0] output_a, result_a;
  logic [15:0] iter_a;
  logic        h_start_b, c_start_b, busy_b, finish_b;
  logic [23:0] output_b, result_b;
  logic [15:0] iter_b;
  logic        h_start_c, c_start_c, busy_c, finish_c;
  logic [3:0]  output_c, result_c, cls_c;
  logic [15:0] iter_c;

  assign cls_c = {cls_s[2][13:12], cls_s[2][1:0]};

  rbm_gibbs_sequencer #(.out_dim(2), .output_bitlength(12), .burn_in(2), .num_samples(3)) dut_a (
    .clock(clock), .reset(reset), .start(start_s[0]), .h_start(h_start_a), .h_done(h_done_s[0]),
    .c_start(c_start_a), .c_done(c_done_s[0]), .ClassI(cls_s[0]), .Output(output_a),
    .ResultO(result_a), .iter(iter_a), .busy(busy_a), .finish(finish_a));

  rbm_gibbs_sequencer #(.out_dim(2), .output_bitlength(12), .burn_in(2), .num_samples(2)) dut_b (
    .clock(clock), .reset(reset), .start(start_s[1]), .h_start(h_start_b), .h_done(h_done_s[1]),
    .c_start(c_start_b), .c_done(c_done_s[1]), .ClassI(cls_s[1]), .Output(output_b),
    .ResultO(result_b), .iter(iter_b), .busy(busy_b), .finish(finish_b));

  rbm_gibbs_sequencer #(.out_dim(2), .output_bitlength(2), .burn_in(0), .num_samples(5)) dut_c (
    .clock(clock), .reset(reset), .start(start_s[2]), .h_start(h_start_c), .h_done(h_done_s[2]),
    .c_start(c_start_c), .c_done(c_done_s[2]), .ClassI(cls_c), .Output(output_c),
    .ResultO(result_c), .iter(iter_c), .busy(busy_c), .finish(finish_c));

  // Present every instance in a common 12-bit-per-element view.
  always_comb begin
    h_st[0] = h_start_a;  c_st[0] = c_start_a;  busy_s[0] = busy_a;  fin_s[0] = finish_a;
    out_s[0] = output_a;  res_s[0] = result_a;  iter_s[0] = iter_a;
    h_st[1] = h_start_b;  c_st[1] = c_start_b;  busy_s[1] = busy_b;  fin_s[1] = finish_b;
    out_s[1] = output_b;  res_s[1] = result_b;  iter_s[1] = iter_b;
    h_st[2] = h_start_c;  c_st[2] = c_start_c;  busy_s[2] = busy_c;  fin_s[2] = finish_c;
    out_s[2] = {10'd0, output_c[3:2], 10'd0, output_c[1:0]};
    res_s[2] = {10'd0, result_c[3:2], 10'd0, result_c[1:0]};
    iter_s[2] = iter_c;
  end

  int cls0[16];
  int cls1[16];
  logic [23:0] exp_out_q[$];
  logic [23:0] exp_res_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic waitCycle();
    @(posedge clock);
    #1;
  endtask

  function automatic int curCycle();
    return edge_cnt - start_edge + 1;
  endfunction

  // One full run on instance idx; hdel/cdel are extra WAIT cycles before each done,
  // robust adds stray dones and a start while busy, abort_it resets in C_WAIT of that iteration.
  task automatic applyStimulus(input int idx, input int burn, input int ns, input int w,
                               input int hdel, input int cdel, input bit robust, input int abort_it);
    int maxv, r0, r1, exp_cycle, n, fin_cycle;
    logic [23:0] e;
    maxv = (1 << w) - 1;
    r0 = 0;
    r1 = 0;
    exp_cycle = 1;
    start_s[idx] = 1'b1;
    @(posedge clock);
    #1;
    start_edge = edge_cnt;
    start_s[idx] = 1'b0;
    checkOutput("busy after start", 32'(busy_s[idx]), 1);
    checkOutput("finish after start", 32'(fin_s[idx]), 0);
    checkOutput("ResultO cleared", 32'(res_s[idx]), 0);
    checkOutput("Output cleared", 32'(out_s[idx]), 0);
    for (int it = 0; it < burn + ns; it++) begin
      n = 0;
      while (!h_st[idx] && n < 40) begin
        waitCycle();
        n++;
      end
      if (!h_st[idx]) begin
        checkOutput("h_start timeout", 0, 1);
        return;
      end
      checkOutput("h_start cycle", curCycle(), exp_cycle);
      checkOutput("iter", 32'(iter_s[idx]), it);
      if (robust) begin
        h_done_s[idx] = 1'b1;
        c_done_s[idx] = 1'b1;
      end
      waitCycle();
      h_done_s[idx] = 1'b0;
      checkOutput("h_start width", 32'(h_st[idx]), 0);
      repeat (hdel) begin
        waitCycle();
        c_done_s[idx] = 1'b0;
      end
      c_done_s[idx] = 1'b0;
      h_done_s[idx] = 1'b1;
      waitCycle();
      h_done_s[idx] = 1'b0;
      checkOutput("c_start", 32'(c_st[idx]), 1);
      if (robust) begin
        c_done_s[idx] = 1'b1;
        start_s[idx]  = 1'b1;
      end
      waitCycle();
      c_done_s[idx] = 1'b0;
      start_s[idx]  = 1'b0;
      checkOutput("c_start width", 32'(c_st[idx]), 0);
      if (it == abort_it) begin
        reset = 1'b1;
        waitCycle();
        reset = 1'b0;
        c_done_s[idx] = 1'b1;
        cls_s[idx] = 24'h00F00F;
        waitCycle();
        c_done_s[idx] = 1'b0;
        checkOutput("reset Output", 32'(out_s[idx]), 0);
        checkOutput("reset ResultO", 32'(res_s[idx]), 0);
        checkOutput("reset iter", 32'(iter_s[idx]), 0);
        repeat (4) begin
          checkOutput("reset h_start", 32'(h_st[idx]), 0);
          checkOutput("reset busy", 32'(busy_s[idx]), 0);
          checkOutput("reset finish", 32'(fin_s[idx]), 0);
          waitCycle();
        end
        return;
      end
      repeat (cdel) waitCycle();
      cls_s[idx] = {12'(cls1[it]), 12'(cls0[it])};
      c_done_s[idx] = 1'b1;
      exp_out_q.push_back({12'(cls1[it]), 12'(cls0[it])});
      waitCycle();
      c_done_s[idx] = 1'b0;
      cls_s[idx] = 24'($urandom);
      e = exp_out_q.pop_front();
      checkOutput("Output", 32'(out_s[idx]), 32'(e));
      if (it >= burn) begin
        r0 = (r0 + cls0[it] > maxv) ? maxv : r0 + cls0[it];
        r1 = (r1 + cls1[it] > maxv) ? maxv : r1 + cls1[it];
      end
      exp_res_q.push_back({12'(r1), 12'(r0)});
      exp_cycle += 5 + hdel + cdel;
      waitCycle();
      e = exp_res_q.pop_front();
      checkOutput("ResultO", 32'(res_s[idx]), 32'(e));
    end
    fin_cycle = fin_s[idx] ? curCycle() : -1;
    checkOutput("finish cycle", fin_cycle, exp_cycle);
    checkOutput("busy in DONE", 32'(busy_s[idx]), 0);
    repeat (3) waitCycle();
    checkOutput("finish holds", 32'(fin_s[idx]), 1);
    checkOutput("ResultO holds", 32'(res_s[idx]), {8'd0, 12'(r1), 12'(r0)});
    checkOutput("iter holds", 32'(iter_s[idx]), burn + ns - 1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_s[i]  = 1'b0;
      h_done_s[i] = 1'b0;
      c_done_s[i] = 1'b0;
      cls_s[i]    = 24'($urandom);
    end
    repeat (3) waitCycle();
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst busy", 32'(busy_s[i]), 0);
      checkOutput("rst finish", 32'(fin_s[i]), 0);
      checkOutput("rst h_start", 32'(h_st[i]), 0);
      checkOutput("rst c_start", 32'(c_st[i]), 0);
      checkOutput("rst ResultO", 32'(res_s[i]), 0);
      checkOutput("rst Output", 32'(out_s[i]), 0);
      checkOutput("rst iter", 32'(iter_s[i]), 0);
    end
    reset = 1'b0;
    waitCycle();

    for (int i = 0; i < 16; i++) begin
      cls0[i] = 1;
      cls1[i] = 0;
    end
    applyStimulus(0, 2, 3, 12, 0, 0, 1'b0, -1);
    checkOutput("basic final", 32'(res_s[0]), {8'd0, 12'd0, 12'd3});
    applyStimulus(0, 2, 3, 12, 0, 0, 1'b0, -1);
    checkOutput("restart final", 32'(res_s[0]), {8'd0, 12'd0, 12'd3});

    cls0[0] = 5; cls1[0] = 0;
    cls0[1] = 5; cls1[1] = 0;
    cls0[2] = 1; cls1[2] = 2;
    cls0[3] = 0; cls1[3] = 4;
    applyStimulus(1, 2, 2, 12, 0, 0, 1'b0, -1);
    checkOutput("burn-in final", 32'(res_s[1]), {8'd0, 12'd6, 12'd1});

    for (int i = 0; i < 16; i++) begin
      cls0[i] = 1;
      cls1[i] = 3;
    end
    applyStimulus(2, 0, 5, 2, 0, 0, 1'b0, -1);
    checkOutput("saturation final", 32'(res_s[2]), {8'd0, 12'd3, 12'd3});

    for (int i = 0; i < 16; i++) begin
      cls0[i] = (i * 7 + 3) % 50;
      cls1[i] = (i * 13 + 1) % 40;
    end
    applyStimulus(0, 2, 3, 12, 7, 1, 1'b1, -1);

    for (int i = 0; i < 16; i++) begin
      cls0[i] = 1;
      cls1[i] = 0;
    end
    applyStimulus(0, 2, 3, 12, 0, 0, 1'b0, 3);
    applyStimulus(0, 2, 3, 12, 0, 0, 1'b0, -1);
    checkOutput("post-reset final", 32'(res_s[0]), {8'd0, 12'd0, 12'd3});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
